// File: rtl/alu_issue_ctrl.sv
// Command-issue front end for the combinational 32-bit ALU: register file, operand
// fetch, result capture/write-back and a valid/ready response channel.
module alu_issue_ctrl #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   // command channel
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [AW-1:0]     cmd_rs1,
   input  logic [AW-1:0]     cmd_rs2,
   input  logic              cmd_imm_en,
   input  logic [DATA_W-1:0] cmd_imm,
   input  logic [AW-1:0]     cmd_rd,
   // ALU initiator side
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   // response channel
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zero,
   output logic [AW-1:0]     rsp_rd,
   // external register preload
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   regs [NREGS];
   logic [AW-1:0]       rd_q;
   logic [DATA_W-1:0]   rs1_val, rs2_val;
   logic                accept;
   logic                wb_en;

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign accept    = cmd_valid && cmd_ready;
   assign wb_en     = (state_q == EXEC) && (rd_q != '0);

   // Register 0 is never written, but the decode keeps it zero by construction too.
   assign rs1_val = (cmd_rs1 == '0) ? '0 : regs[cmd_rs1];
   assign rs2_val = (cmd_rs2 == '0) ? '0 : regs[cmd_rs2];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_valid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_sel  <= '0;
         rd_q     <= '0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         rsp_rd   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            alu_a   <= rs1_val;
            alu_b   <= cmd_imm_en ? cmd_imm : rs2_val;
            alu_sel <= cmd_op;
            rd_q    <= cmd_rd;
         end
         if (state_q == EXEC) begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_rd   <= rd_q;
         end
      end
   end

   // NOTE: the register file is reset here because it must read all-zero after reset;
   // a plain storage array would normally be left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
         // Later assignment wins: write-back overrides a same-edge external write.
         if (wb_en) regs[rd_q] <= alu_result;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, vector table with a
// response scoreboard, plus hand sequences for reset, backpressure and collisions.
module tb_alu_issue_ctrl;

   localparam int DW = 32;
   localparam int AW = 3;

   logic          clk, rst_n;
   logic          cmd_valid, cmd_ready, cmd_imm_en;
   logic [2:0]    cmd_op;
   logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
   logic [DW-1:0] cmd_imm;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [2:0]    alu_sel;
   logic          alu_zero;
   logic          rsp_valid, rsp_ready, rsp_zero;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] rsp_rd;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          zero;
      logic [AW-1:0] rd;
   } rsp_t;
   rsp_t sb_q[$];

   typedef struct {
      bit            pre_en;
      logic [AW-1:0] pre_addr;
      logic [DW-1:0] pre_data;
      logic [2:0]    op;
      logic [AW-1:0] rs1, rs2;
      bit            imm_en;
      logic [DW-1:0] imm;
      logic [AW-1:0] rd;
      logic [DW-1:0] exp_data;
      bit            exp_zero;
   } vec_t;
   vec_t vecs[14];

   alu_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm_en(cmd_imm_en),
      .cmd_imm(cmd_imm), .cmd_rd(cmd_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_rd(rsp_rd),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the combinational ALU.
   always_comb begin
      alu_result = '0;
      case (alu_sel)
         3'd0: alu_result = alu_a + alu_b;
         3'd1: alu_result = alu_a - alu_b;
         3'd2: alu_result = alu_a & alu_b;
         3'd3: alu_result = alu_a | alu_b;
         3'd4: alu_result = alu_a ^ alu_b;
         3'd5: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         3'd6: alu_result = alu_a << alu_b[4:0];
         3'd7: alu_result = alu_a >> alu_b[4:0];
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                               input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input bit ie, input logic [DW-1:0] imm, input logic [AW-1:0] rd,
                               input logic [DW-1:0] ed, input bit ez);
      vec_t v;
      v.pre_en = pe; v.pre_addr = pa; v.pre_data = pd;
      v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm_en = ie; v.imm = imm; v.rd = rd;
      v.exp_data = ed; v.exp_zero = ez;
      return v;
   endfunction

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      rsp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_data"}, rsp_data, e.data);
         check({tag, "_zero"}, 32'(rsp_zero), 32'(e.zero));
         check({tag, "_rd"}, 32'(rsp_rd), 32'(e.rd));
      end
   endtask

   task automatic drive_cmd(input vec_t v);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2;
      cmd_imm_en = v.imm_en; cmd_imm = v.imm; cmd_rd = v.rd;
   endtask

   // Issue one command from a negedge in IDLE and return at the negedge after the
   // response handshake. Optional external writes on the accept or write-back edge.
   task automatic run_cmd(input string tag, input vec_t v,
                          input bit wr_acc, input bit wr_exe,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      rsp_t e;
      int   n;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      check({tag, "_ready_wait"}, 32'(cmd_ready), 32'd1);
      drive_cmd(v);
      e.data = v.exp_data; e.zero = v.exp_zero; e.rd = v.rd;
      sb_q.push_back(e);
      if (wr_acc) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
      @(negedge clk);                       // after accept edge E0
      cmd_valid = 1'b0; wr_en = 1'b0;
      check({tag, "_alu_sel"}, 32'(alu_sel), 32'(v.op));
      check({tag, "_valid_early"}, 32'(rsp_valid), 32'd0);
      if (wr_exe) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
      @(negedge clk);                       // after capture edge E1
      wr_en = 1'b0;
      check({tag, "_valid_lat"}, 32'(rsp_valid), 32'd1);
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      pop_check(tag);
      @(negedge clk);                       // after handshake edge E2
   endtask

   initial begin
      vec_t v, held;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0;
      cmd_imm_en = 1'b0; cmd_imm = '0; cmd_rd = '0; rsp_ready = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;

      //                pre  addr data          op  rs1 rs2 imm imm_val        rd  exp          zero
      vecs[0]  = mk(0, 0, 0,            3'd0, 3, 0, 1, 32'h0,          0, 32'h0,        1); // R3 after reset
      vecs[1]  = mk(0, 0, 0,            3'd0, 1, 2, 0, 32'h0,          4, 32'd8,        0); // 5+3
      vecs[2]  = mk(0, 0, 0,            3'd3, 4, 0, 1, 32'h0,          5, 32'd8,        0); // R4|0
      vecs[3]  = mk(0, 0, 0,            3'd1, 1, 1, 0, 32'h0,          0, 32'h0,        1); // R1-R1 to R0
      vecs[4]  = mk(0, 0, 0,            3'd0, 0, 0, 1, 32'h0,          6, 32'h0,        1); // R0 reads 0
      vecs[5]  = mk(0, 0, 0,            3'd1, 2, 1, 0, 32'h0,          3, 32'hFFFFFFFE, 0); // 3-5 wraps
      vecs[6]  = mk(0, 0, 0,            3'd4, 4, 0, 1, 32'd8,          6, 32'h0,        1); // 8^8
      vecs[7]  = mk(0, 0, 0,            3'd2, 1, 0, 1, 32'hFFFFFFFC,   7, 32'd4,        0); // 5&~3
      vecs[8]  = mk(0, 0, 0,            3'd7, 4, 0, 1, 32'd2,          7, 32'd2,        0); // 8>>2
      vecs[9]  = mk(1, 1, 32'hFFFFFFFF, 3'd0, 1, 0, 1, 32'd1,          0, 32'h0,        1); // add wraps
      vecs[10] = mk(1, 2, 32'd1,        3'd5, 1, 2, 0, 32'h0,          3, 32'd1,        0); // -1 < 1
      vecs[11] = mk(1, 1, 32'd1,        3'd6, 1, 0, 1, 32'h21,         5, 32'd2,        0); // 1<<(33&31)
      vecs[12] = mk(0, 0, 0,            3'd7, 3, 0, 1, 32'h0,          2, 32'd1,        0); // R3 written by slt
      vecs[13] = mk(0, 0, 0,            3'd0, 5, 5, 0, 32'h0,          0, 32'd4,        0); // 2+2

      // ---- reset values
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);

      // ---- reset asserted mid-EXEC discards the command (would write R3=7)
      v = mk(0, 0, 0, 3'd0, 0, 0, 1, 32'd7, 3, 32'd7, 0);
      drive_cmd(v);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      check("exec_alu_b", alu_b, 32'd7);
      rst_n = 1'b0;
      #1;
      check("rst_mid_alu_b", alu_b, 32'd0);
      check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rel_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rel_rsp_rd", 32'(rsp_rd), 32'd0);

      // ---- vector table
      preload(1, 32'd5);
      preload(2, 32'd3);
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].pre_en) preload(vecs[i].pre_addr, vecs[i].pre_data);
         run_cmd($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0, '0, '0);
      end
      // R1=1 R2=1 R3=1 R4=8 R5=2 R6=0 R7=2

      // ---- backpressure: response held 10 cycles, queued command waits
      v    = mk(0, 0, 0, 3'd0, 1, 5, 0, 32'h0, 6, 32'd3, 0);
      held = mk(0, 0, 0, 3'd0, 6, 0, 1, 32'd10, 7, 32'd13, 0);
      rsp_ready = 1'b0;
      drive_cmd(v);
      sb_q.push_back('{data: 32'd3, zero: 1'b0, rd: 3'd6});
      @(negedge clk);
      drive_cmd(held);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
         check($sformatf("bp_data%0d", i), rsp_data, 32'd3);
         check($sformatf("bp_ready%0d", i), 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      pop_check("bp");
      rsp_ready = 1'b1;
      sb_q.push_back('{data: 32'd13, zero: 1'b0, rd: 3'd7});
      @(negedge clk);
      check("bp_hs_ready", 32'(cmd_ready), 32'd1);
      check("bp_hs_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp_held_accepted", 32'(cmd_ready), 32'd0);
      check("bp_held_alu_a", alu_a, 32'd3);
      check("bp_held_alu_b", alu_b, 32'd10);
      @(negedge clk);
      check("bp_held_valid", 32'(rsp_valid), 32'd1);
      pop_check("bp_held");
      @(negedge clk);

      // ---- collisions
      v = mk(0, 0, 0, 3'd0, 1, 5, 0, 32'h0, 2, 32'd3, 0);
      run_cmd("col_wb", v, 1'b0, 1'b1, 3'd2, 32'h0000AAAA);
      v = mk(0, 0, 0, 3'd0, 2, 0, 1, 32'h0, 0, 32'd3, 0);
      run_cmd("col_acc", v, 1'b1, 1'b0, 3'd2, 32'h55);
      v = mk(0, 0, 0, 3'd0, 2, 0, 1, 32'h0, 0, 32'h55, 0);
      run_cmd("col_after", v, 1'b0, 1'b0, '0, '0);
      v = mk(0, 0, 0, 3'd0, 1, 1, 0, 32'h0, 4, 32'd2, 0);
      run_cmd("col_other", v, 1'b0, 1'b1, 3'd5, 32'h100);
      v = mk(0, 0, 0, 3'd0, 5, 0, 1, 32'h0, 0, 32'h100, 0);
      run_cmd("col_other_r5", v, 1'b0, 1'b0, '0, '0);
      v = mk(0, 0, 0, 3'd0, 4, 0, 1, 32'h0, 0, 32'd2, 0);
      run_cmd("col_other_r4", v, 1'b0, 1'b0, '0, '0);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
